// File: rtl/nco_track_pkg.sv
// Shared constants for the tracking-channel NCO family: default widths and the
// increment-mode encoding that the channel register map also decodes.
package nco_defs;

   // Default widths of a production tracking-channel NCO.
   localparam int NCO_ACC_WIDTH   = 32;
   localparam int NCO_INC_WIDTH   = 32;
   localparam int NCO_OUT_WIDTH   = 4;
   localparam int NCO_CYCLE_WIDTH = 16;

   // Increment-mode bit as written through the channel register map.
   localparam logic INC_IMMEDIATE = 1'b0;
   localparam logic INC_AT_WRAP   = 1'b1;

endpackage : nco_defs

// File: rtl/nco_track_inc_ctrl.sv
// Increment control for nco_track: holds the active increment, a shadow copy
// for deferred writes, and the pending flag that promotes the shadow on a wrap.
module nco_inc_ctrl
   import nco_defs::*;
#(
   parameter int PHASE_INC_WIDTH = NCO_INC_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       carry,
   input  logic                       inc_valid,
   input  logic                       inc_at_wrap,
   input  logic [PHASE_INC_WIDTH-1:0] inc,
   output logic [PHASE_INC_WIDTH-1:0] inc_active,
   output logic                       inc_pending
);

   logic [PHASE_INC_WIDTH-1:0] r_inc_active;
   logic [PHASE_INC_WIDTH-1:0] r_inc_shadow;
   logic                       r_inc_pending;
   logic                       w_immediate;
   logic                       w_promote;

   assign w_immediate = inc_valid && (inc_at_wrap == INC_IMMEDIATE);
   assign w_promote   = carry && r_inc_pending;

   // Apply immediate writes, capture deferred writes, promote the shadow on a wrap.
   always_ff @(posedge clk) begin
      // NOTE: every register here is reset synchronously, including the shadow,
      // so a pending value from before reset can never leak into inc_active.
      if (reset) begin
         r_inc_active  <= '0;
         r_inc_shadow  <= '0;
         r_inc_pending <= 1'b0;
      end else if (w_immediate) begin
         // An immediate write wins over a coincident promotion and cancels
         // any deferred value; the shadow is simply left stale.
         r_inc_active  <= inc;
         r_inc_pending <= 1'b0;
      end else begin
         if (w_promote) begin
            r_inc_active <= r_inc_shadow;
         end
         if (inc_valid) begin
            // Deferred write: last write wins; if it lands on a wrap the new
            // value waits for the following wrap.
            r_inc_shadow  <= inc;
            r_inc_pending <= 1'b1;
         end else if (w_promote) begin
            r_inc_pending <= 1'b0;
         end
      end
   end

   assign inc_active  = r_inc_active;
   assign inc_pending = r_inc_pending;

endmodule : nco_inc_ctrl

// File: rtl/nco_track.sv
// Phase-accumulator NCO for the tracking channels: run enable, immediate or
// wrap-aligned increment updates, direct phase load, registered wrap pulse and
// a saturating wrap counter with atomic snapshot.
module nco_track
   import nco_defs::*;
#(
   parameter int ACC_WIDTH       = NCO_ACC_WIDTH,
   parameter int PHASE_INC_WIDTH = NCO_INC_WIDTH,
   parameter int OUTPUT_WIDTH    = NCO_OUT_WIDTH,
   parameter int CYCLE_WIDTH     = NCO_CYCLE_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       inc_valid,
   input  logic [PHASE_INC_WIDTH-1:0] inc,
   input  logic                       inc_at_wrap,
   input  logic                       phase_load,
   input  logic [ACC_WIDTH-1:0]       phase_in,
   input  logic                       snapshot,
   output logic [OUTPUT_WIDTH-1:0]    out,
   output logic                       wrap,
   output logic [CYCLE_WIDTH-1:0]     cycle_count,
   output logic                       inc_pending,
   output logic [ACC_WIDTH-1:0]       snap_phase,
   output logic [CYCLE_WIDTH-1:0]     snap_cycles,
   output logic                       snap_valid
);

   logic [ACC_WIDTH-1:0]       r_acc;
   logic                       r_wrap;
   logic [CYCLE_WIDTH-1:0]     r_cycle_count;
   logic [ACC_WIDTH-1:0]       r_snap_phase;
   logic [CYCLE_WIDTH-1:0]     r_snap_cycles;
   logic                       r_snap_valid;

   logic [PHASE_INC_WIDTH-1:0] w_inc_active;
   logic [ACC_WIDTH-1:0]       w_inc_ext;
   logic [ACC_WIDTH:0]         w_sum;
   logic                       w_carry;
   logic [ACC_WIDTH-1:0]       w_acc_next;
   logic [CYCLE_WIDTH-1:0]     w_cnt_next;

   // Increment registers live in their own block so the loop-filter write
   // semantics can be reviewed in isolation.
   nco_inc_ctrl #(
      .PHASE_INC_WIDTH (PHASE_INC_WIDTH)
   ) u_inc_ctrl (
      .clk         (clk),
      .reset       (reset),
      .carry       (w_carry),
      .inc_valid   (inc_valid),
      .inc_at_wrap (inc_at_wrap),
      .inc         (inc),
      .inc_active  (w_inc_active),
      .inc_pending (inc_pending)
   );

   assign w_inc_ext = ACC_WIDTH'(w_inc_active);
   assign w_sum     = {1'b0, r_acc} + {1'b0, w_inc_ext};

   // Next accumulator value and carry: load beats accumulate; a load or an
   // idle cycle never produces a carry.
   always_comb begin
      w_acc_next = r_acc;
      w_carry    = 1'b0;
      if (phase_load) begin
         w_acc_next = phase_in;
      end else if (enable) begin
         w_acc_next = w_sum[ACC_WIDTH-1:0];
         w_carry    = w_sum[ACC_WIDTH];
      end
   end

   // Wrap count including this cycle's carry, saturating at all-ones.
   always_comb begin
      w_cnt_next = r_cycle_count;
      if (w_carry && (r_cycle_count != {CYCLE_WIDTH{1'b1}})) begin
         w_cnt_next = r_cycle_count + 1'b1;
      end
   end

   // Accumulator, wrap pulse, wrap counter and snapshot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc         <= '0;
         r_wrap        <= 1'b0;
         r_cycle_count <= '0;
         r_snap_phase  <= '0;
         r_snap_cycles <= '0;
         r_snap_valid  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the pre-edge values of its neighbours regardless of order.
         r_acc        <= w_acc_next;
         r_wrap       <= w_carry;
         r_snap_valid <= snapshot;
         if (snapshot) begin
            // Capture and clear atomically so no wrap is lost or double counted.
            r_snap_phase  <= w_acc_next;
            r_snap_cycles <= w_cnt_next;
            r_cycle_count <= '0;
         end else begin
            r_cycle_count <= w_cnt_next;
         end
      end
   end

   assign out         = r_acc[ACC_WIDTH-1 -: OUTPUT_WIDTH];
   assign wrap        = r_wrap;
   assign cycle_count = r_cycle_count;
   assign snap_phase  = r_snap_phase;
   assign snap_cycles = r_snap_cycles;
   assign snap_valid  = r_snap_valid;

endmodule : nco_track

// File: tb/tb_nco_track.sv
// Directed self-checking bench for nco_track with ACC=8, INC=8, OUT=4, CYCLE=4.
module tb_nco_track;

   localparam int ACC = 8;
   localparam int INC = 8;
   localparam int OUTW = 4;
   localparam int CYC = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic            inc_valid;
   logic [INC-1:0]  inc;
   logic            inc_at_wrap;
   logic            phase_load;
   logic [ACC-1:0]  phase_in;
   logic            snapshot;
   logic [OUTW-1:0] out;
   logic            wrap;
   logic [CYC-1:0]  cycle_count;
   logic            inc_pending;
   logic [ACC-1:0]  snap_phase;
   logic [CYC-1:0]  snap_cycles;
   logic            snap_valid;

   int n_checks = 0;
   int n_errors = 0;

   nco_track #(
      .ACC_WIDTH       (ACC),
      .PHASE_INC_WIDTH (INC),
      .OUTPUT_WIDTH    (OUTW),
      .CYCLE_WIDTH     (CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .inc_valid   (inc_valid),
      .inc         (inc),
      .inc_at_wrap (inc_at_wrap),
      .phase_load  (phase_load),
      .phase_in    (phase_in),
      .snapshot    (snapshot),
      .out         (out),
      .wrap        (wrap),
      .cycle_count (cycle_count),
      .inc_pending (inc_pending),
      .snap_phase  (snap_phase),
      .snap_cycles (snap_cycles),
      .snap_valid  (snap_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      enable      = 1'b0;
      inc_valid   = 1'b0;
      inc         = '0;
      inc_at_wrap = 1'b0;
      phase_load  = 1'b0;
      phase_in    = '0;
      snapshot    = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();

      // 1. Reset with a deferred write issued beforehand and inputs busy.
      reset       = 1'b0;
      inc_valid   = 1'b1;
      inc_at_wrap = 1'b1;
      inc         = 8'h55;
      tick();
      check("pre_reset_pending", 32'(inc_pending), 32'h1);
      reset       = 1'b1;
      enable      = 1'b1;
      phase_load  = 1'b1;
      phase_in    = 8'hAA;
      snapshot    = 1'b1;
      inc_at_wrap = 1'b0;
      tick();
      check("rst_out", 32'(out), 32'h0);
      check("rst_wrap", 32'(wrap), 32'h0);
      check("rst_count", 32'(cycle_count), 32'h0);
      check("rst_pending", 32'(inc_pending), 32'h0);
      check("rst_snap_phase", 32'(snap_phase), 32'h0);
      check("rst_snap_cycles", 32'(snap_cycles), 32'h0);
      check("rst_snap_valid", 32'(snap_valid), 32'h0);

      // 2. Immediate inc=0x40, then run: 0x40, 0x80, 0xC0, 0x00 with a wrap.
      reset = 1'b0;
      idle_inputs();
      inc_valid = 1'b1;
      inc       = 8'h40;
      tick();
      check("t2_out_hold", 32'(out), 32'h0);
      inc_valid = 1'b0;
      enable    = 1'b1;
      tick();
      check("t2_out_40", 32'(out), 32'h4);
      tick();
      check("t2_out_80", 32'(out), 32'h8);
      check("t2_wrap_80", 32'(wrap), 32'h0);
      tick();
      check("t2_out_c0", 32'(out), 32'hC);
      tick();
      check("t2_out_00", 32'(out), 32'h0);
      check("t2_wrap", 32'(wrap), 32'h1);
      check("t2_count", 32'(cycle_count), 32'h1);
      tick();
      check("t2_out_40b", 32'(out), 32'h4);
      check("t2_wrap_clr", 32'(wrap), 32'h0);

      // 3. Deferred inc=0x10 at acc=0x40, promoted on the next wrap.
      inc_valid   = 1'b1;
      inc_at_wrap = 1'b1;
      inc         = 8'h10;
      tick();
      check("t3_out_80", 32'(out), 32'h8);
      check("t3_pending", 32'(inc_pending), 32'h1);
      inc_valid = 1'b0;
      tick();
      check("t3_out_c0", 32'(out), 32'hC);
      check("t3_pending_hold", 32'(inc_pending), 32'h1);
      tick();
      check("t3_out_00", 32'(out), 32'h0);
      check("t3_wrap", 32'(wrap), 32'h1);
      check("t3_promoted", 32'(inc_pending), 32'h0);
      check("t3_count", 32'(cycle_count), 32'h2);
      tick();
      check("t3_out_10", 32'(out), 32'h1);
      tick();
      check("t3_out_20", 32'(out), 32'h2);

      // 4. Load 0xF0 alongside enable and an immediate inc=0x20.
      phase_load  = 1'b1;
      phase_in    = 8'hF0;
      inc_valid   = 1'b1;
      inc_at_wrap = 1'b0;
      inc         = 8'h20;
      tick();
      check("t4_out_f0", 32'(out), 32'hF);
      check("t4_no_wrap", 32'(wrap), 32'h0);
      check("t4_count_hold", 32'(cycle_count), 32'h2);
      phase_load = 1'b0;
      inc_valid  = 1'b0;
      tick();
      check("t4_out_10", 32'(out), 32'h1);
      check("t4_wrap", 32'(wrap), 32'h1);
      check("t4_count", 32'(cycle_count), 32'h3);

      // 5. Snapshot on a carry cycle with count=3, then back-to-back.
      phase_load = 1'b1;
      tick();
      check("t5_count_pre", 32'(cycle_count), 32'h3);
      phase_load = 1'b0;
      snapshot   = 1'b1;
      tick();
      check("t5_snap_cycles", 32'(snap_cycles), 32'h4);
      check("t5_snap_phase", 32'(snap_phase), 32'h10);
      check("t5_snap_valid", 32'(snap_valid), 32'h1);
      check("t5_count_clr", 32'(cycle_count), 32'h0);
      tick();
      check("t5_b2b_cycles", 32'(snap_cycles), 32'h0);
      check("t5_b2b_phase", 32'(snap_phase), 32'h30);
      check("t5_b2b_valid", 32'(snap_valid), 32'h1);
      snapshot = 1'b0;
      tick();
      check("t5_valid_drop", 32'(snap_valid), 32'h0);
      check("t5_out_50", 32'(out), 32'h5);

      // 6. inc=0xFF wraps every cycle: counter saturates at 0xF.
      inc_valid = 1'b1;
      inc       = 8'hFF;
      tick();
      check("t6_out_70", 32'(out), 32'h7);
      inc_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("t6_count_sat", 32'(cycle_count), 32'hF);
      check("t6_wrap", 32'(wrap), 32'h1);
      check("t6_out_5c", 32'(out), 32'h5);
      // Deferred 0x01 then an immediate 0x02 that cancels it.
      inc_valid   = 1'b1;
      inc_at_wrap = 1'b1;
      inc         = 8'h01;
      tick();
      check("t6_pending", 32'(inc_pending), 32'h1);
      inc_at_wrap = 1'b0;
      inc         = 8'h02;
      tick();
      check("t6_cancel", 32'(inc_pending), 32'h0);
      inc_valid = 1'b0;
      // acc is 0x5A; 83 steps of 2 reach 0x100 and wrap to 0x00.
      for (int i = 0; i < 83; i++) tick();
      check("t6_wrap2", 32'(wrap), 32'h1);
      check("t6_out_00", 32'(out), 32'h0);
      check("t6_count_held", 32'(cycle_count), 32'hF);
      snapshot = 1'b1;
      tick();
      snapshot = 1'b0;
      check("t6_shadow_unused", 32'(snap_phase), 32'h02);
      check("t6_snap_cycles", 32'(snap_cycles), 32'hF);
      check("t6_no_pending", 32'(inc_pending), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_nco_track
